// File: rtl/ps2_note_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_note_decoder
// Purpose  : Turns a PS/2 scan-set-2 byte stream into note-on/note-off events.
//            Tracks E0/F0 prefixes, maps two piano-style key rows to notes,
//            handles octave up/down on the arrow keys and queues events in a
//            small FIFO with a valid/ready handshake.
// Ports    : CLK, RST (async, active high)
//            CODEWORD[7:0] - scan byte, non-zero = one valid byte this cycle
//            EV_VALID/EV_READY - event handshake; EV_NOTE[6:0], EV_ON = head
//            GATE     - some mapped note key is held
//            OCTAVE   - current octave
//            OVERFLOW - sticky, an event was dropped on a full FIFO
// Options  : define PS2_NOTE_TIMEOUT_EN to abandon a prefix sequence after
//            TIMEOUT_CYCLES cycles without a byte.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_note_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int BASE_NOTE      = 24,
  parameter int OCT_INIT       = 2,
  parameter int OCT_MAX        = 5,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] CODEWORD,
  output logic       EV_VALID,
  input  logic       EV_READY,
  output logic [6:0] EV_NOTE,
  output logic       EV_ON,
  output logic       GATE,
  output logic [2:0] OCTAVE,
  output logic       OVERFLOW
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Elaboration-time sanity check on the configuration.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      OCT_MAX > 7 || OCT_INIT > OCT_MAX || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ps2_note_decoder: illegal parameter set");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  // Returns {hit, index}.
  function automatic logic [5:0] key_lookup(input logic [7:0] code);
    case (code)
      8'h1A: key_lookup = {1'b1, 5'd0};
      8'h1B: key_lookup = {1'b1, 5'd1};
      8'h22: key_lookup = {1'b1, 5'd2};
      8'h23: key_lookup = {1'b1, 5'd3};
      8'h21: key_lookup = {1'b1, 5'd4};
      8'h2A: key_lookup = {1'b1, 5'd5};
      8'h34: key_lookup = {1'b1, 5'd6};
      8'h32: key_lookup = {1'b1, 5'd7};
      8'h33: key_lookup = {1'b1, 5'd8};
      8'h31: key_lookup = {1'b1, 5'd9};
      8'h3B: key_lookup = {1'b1, 5'd10};
      8'h3A: key_lookup = {1'b1, 5'd11};
      8'h15: key_lookup = {1'b1, 5'd12};
      8'h1E: key_lookup = {1'b1, 5'd13};
      8'h1D: key_lookup = {1'b1, 5'd14};
      8'h26: key_lookup = {1'b1, 5'd15};
      8'h24: key_lookup = {1'b1, 5'd16};
      8'h2D: key_lookup = {1'b1, 5'd17};
      8'h2E: key_lookup = {1'b1, 5'd18};
      8'h2C: key_lookup = {1'b1, 5'd19};
      8'h36: key_lookup = {1'b1, 5'd20};
      8'h35: key_lookup = {1'b1, 5'd21};
      8'h3D: key_lookup = {1'b1, 5'd22};
      8'h3C: key_lookup = {1'b1, 5'd23};
      default: key_lookup = 6'd0;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [23:0]       held_q, held_d;
  logic              gate_q, gate_d;
  logic [2:0]        octave_q, octave_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        mem_q [FIFO_DEPTH];   // {on, note}
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ev_valid_q, ev_valid_d;
  logic [6:0]        ev_note_q, ev_note_d;
  logic              ev_on_q, ev_on_d;

  logic              byte_v, key_hit, ev_push, ev_on_new, do_push, do_pop, full;
  logic [4:0]        key_idx;
  logic [7:0]        note_sum;

`ifdef PS2_NOTE_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0]  tmr_q, tmr_d;
`endif

  always_comb begin
    byte_v             = (CODEWORD != 8'd0);
    {key_hit, key_idx} = key_lookup(CODEWORD);
    note_sum           = 8'(BASE_NOTE) + (8'(octave_q) * 8'd12) + 8'(key_idx);

    state_d   = state_q;
    held_d    = held_q;
    octave_d  = octave_q;
    ev_push   = 1'b0;
    ev_on_new = 1'b0;

    if (byte_v) begin
      case (state_q)
        IDLE: begin
          if (CODEWORD == 8'hE0) begin
            state_d = EXT;
          end else if (CODEWORD == 8'hF0) begin
            state_d = BRK;
          end else if (key_hit && !held_q[key_idx]) begin
            // An already-held key is typematic repeat and is dropped.
            held_d[key_idx] = 1'b1;
            ev_push         = 1'b1;
            ev_on_new       = 1'b1;
          end
        end
        EXT: begin
          state_d = IDLE;
          // Octave is frozen while notes sound so releases match their presses.
          if (CODEWORD == 8'hF0) begin
            state_d = EXT_BRK;
          end else if (CODEWORD == 8'h75 && !gate_q && octave_q != 3'(OCT_MAX)) begin
            octave_d = octave_q + 3'd1;
          end else if (CODEWORD == 8'h72 && !gate_q && octave_q != 3'd0) begin
            octave_d = octave_q - 3'd1;
          end
        end
        BRK: begin
          state_d = IDLE;
          if (key_hit && held_q[key_idx]) begin
            held_d[key_idx] = 1'b0;
            ev_push         = 1'b1;
          end
        end
        default: state_d = IDLE;   // EXT_BRK: extended releases are ignored
      endcase
    end

`ifdef PS2_NOTE_TIMEOUT_EN
    tmr_d = tmr_q;
    if (byte_v || state_q == IDLE) begin
      tmr_d = '0;
    end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
      tmr_d   = '0;
      state_d = IDLE;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end
`endif

    gate_d = |held_d;

    // FIFO: a full FIFO still accepts a push when the head leaves this cycle.
    full       = (count_q == CNT_W'(FIFO_DEPTH));
    do_pop     = ev_valid_q && EV_READY;
    do_push    = ev_push && (!full || do_pop);
    overflow_d = overflow_q | (ev_push && full && !do_pop);

    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = {ev_on_new, note_sum[6:0]};
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

    // Head outputs are registered from the next FIFO state.
    ev_valid_d = (count_d != '0);
    ev_note_d  = ev_valid_d ? mem_d[rd_ptr_d][6:0] : 7'd0;
    ev_on_d    = ev_valid_d ? mem_d[rd_ptr_d][7]   : 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      held_q     <= '0;
      gate_q     <= 1'b0;
      octave_q   <= 3'(OCT_INIT);
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ev_valid_q <= 1'b0;
      ev_note_q  <= '0;
      ev_on_q    <= 1'b0;
`ifdef PS2_NOTE_TIMEOUT_EN
      tmr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      gate_q     <= gate_d;
      octave_q   <= octave_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ev_valid_q <= ev_valid_d;
      ev_note_q  <= ev_note_d;
      ev_on_q    <= ev_on_d;
`ifdef PS2_NOTE_TIMEOUT_EN
      tmr_q      <= tmr_d;
`endif
    end
  end

  assign EV_VALID = ev_valid_q;
  assign EV_NOTE  = ev_note_q;
  assign EV_ON    = ev_on_q;
  assign GATE     = gate_q;
  assign OCTAVE   = octave_q;
  assign OVERFLOW = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_note_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_note_decoder
// Purpose  : Directed bench for ps2_note_decoder. Expected events are queued
//            when bytes are driven and compared as the DUT hands them out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_note_decoder;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] CODEWORD = 8'd0;
  logic       EV_READY = 1'b0;
  logic       EV_VALID, EV_ON, GATE, OVERFLOW;
  logic [6:0] EV_NOTE;
  logic [2:0] OCTAVE;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];   // {on, note}

  always #5 CLK = ~CLK;

  ps2_note_decoder #(
    .FIFO_DEPTH(4), .BASE_NOTE(24), .OCT_INIT(2), .OCT_MAX(5), .TIMEOUT_CYCLES(100)
  ) dut (
    .CLK(CLK), .RST(RST), .CODEWORD(CODEWORD),
    .EV_VALID(EV_VALID), .EV_READY(EV_READY), .EV_NOTE(EV_NOTE), .EV_ON(EV_ON),
    .GATE(GATE), .OCTAVE(OCTAVE), .OVERFLOW(OVERFLOW)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ev(input int oct, input int idx, input logic on);
    int n;
    n  = 24 + 12 * oct + idx;
    ev = {on, 7'(n)};
  endfunction

  // One clock; any handshake that completes on this edge is checked just before it.
  task automatic tick();
    logic [7:0] e;
    @(negedge CLK);
    if (EV_VALID && EV_READY) begin
      if (exp_q.size() == 0) begin
        chk("spurious_event", 32'(EV_VALID), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ev_note", 32'(EV_NOTE), 32'(e[6:0]));
        chk("ev_on", 32'(EV_ON), 32'(e[7]));
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    CODEWORD = b;
    tick();
    CODEWORD = 8'd0;
  endtask

  task automatic drain();
    EV_READY = 1'b1;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || EV_VALID); i++) tick();
    chk("drain_ev_valid", 32'(EV_VALID), 32'd0);
    chk("drain_missing_events", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    RST      = 1'b1;
    CODEWORD = 8'd0;
    EV_READY = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  logic [7:0] low_keys [8] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32};
  logic [7:0] up_keys  [6] = '{8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D};

  initial begin
    // Reset values
    do_reset();
    chk("rst_ev_valid", 32'(EV_VALID), 32'd0);
    chk("rst_ev_note", 32'(EV_NOTE), 32'd0);
    chk("rst_ev_on", 32'(EV_ON), 32'd0);
    chk("rst_gate", 32'(GATE), 32'd0);
    chk("rst_octave", 32'(OCTAVE), 32'd2);
    chk("rst_overflow", 32'(OVERFLOW), 32'd0);

    // Basic make / break
    EV_READY = 1'b1;
    exp_q.push_back(ev(2, 0, 1'b1));
    send(8'h1A);
    chk("gate_on", 32'(GATE), 32'd1);
    drain();
    send(8'hF0);
    exp_q.push_back(ev(2, 0, 1'b0));
    send(8'h1A);
    chk("gate_off", 32'(GATE), 32'd0);
    drain();

    // Typematic repeat suppressed
    exp_q.push_back(ev(2, 12, 1'b1));
    send(8'h15); send(8'h15); send(8'h15);
    drain();
    send(8'hF0);
    exp_q.push_back(ev(2, 12, 1'b0));
    send(8'h15);
    drain();

    // Octave up with saturation, then arrows frozen while a key is held
    for (int i = 0; i < 4; i++) begin
      send(8'hE0);
      send(8'h75);
      chk("octave_up", 32'(OCTAVE), (i < 3) ? 32'(3 + i) : 32'd5);
    end
    exp_q.push_back(ev(5, 0, 1'b1));
    send(8'h1A);
    drain();
    send(8'hE0); send(8'h72);
    chk("octave_frozen", 32'(OCTAVE), 32'd5);
    send(8'hF0);
    exp_q.push_back(ev(5, 0, 1'b0));
    send(8'h1A);
    drain();
    send(8'hE0); send(8'h72);
    chk("octave_down", 32'(OCTAVE), 32'd4);

    // Overflow: 8 presses with consumer stalled, only 4 kept
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 4) exp_q.push_back(ev(2, i, 1'b1));
      send(low_keys[i]);
    end
    chk("ovf_set", 32'(OVERFLOW), 32'd1);
    chk("ovf_valid", 32'(EV_VALID), 32'd1);
    drain();

    // Full FIFO with push and pop on the same edge
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ev(2, 12 + i, 1'b1));
      send(up_keys[i]);
    end
    chk("full_no_ovf", 32'(OVERFLOW), 32'd0);
    EV_READY = 1'b1;
    exp_q.push_back(ev(2, 16, 1'b1));
    send(up_keys[4]);
    EV_READY = 1'b0;
    chk("pushpop_no_ovf", 32'(OVERFLOW), 32'd0);
    send(up_keys[5]);            // FIFO must still be full: dropped
    chk("still_full_ovf", 32'(OVERFLOW), 32'd1);
    drain();

    // Reset in the middle of a prefix discards it
    do_reset();
    send(8'hF0);
    do_reset();
    EV_READY = 1'b1;
    exp_q.push_back(ev(2, 0, 1'b1));
    send(8'h1A);
    drain();
    send(8'hF0);
    exp_q.push_back(ev(2, 0, 1'b0));
    send(8'h1A);
    drain();

    // Long gap after a break prefix
    send(8'hF0);
    repeat (120) tick();
`ifdef PS2_NOTE_TIMEOUT_EN
    exp_q.push_back(ev(2, 0, 1'b1));
    send(8'h1A);
    chk("timeout_gate", 32'(GATE), 32'd1);
`else
    send(8'h1A);
    chk("no_timeout_gate", 32'(GATE), 32'd0);
`endif
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
